// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR stimulus driver: FSM states,
// waveform mode codes, waveform amplitudes and the LFSR definition.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        STREAM,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_IMPULSE = 2'd0,
        MODE_STEP    = 2'd1,
        MODE_RAMP    = 2'd2,
        MODE_LFSR    = 2'd3
    } mode_e;

    localparam logic [7:0] IMPULSE_AMP = 8'h7F;
    localparam logic [7:0] STEP_AMP    = 8'h40;
    localparam logic [7:0] LFSR_SEED   = 8'h01;
    // x^8+x^6+x^5+x^4+1: feedback taken from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS   = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fir_stim_pattern_gen.sv
// Test waveform source: presents the current sample for the selected mode and
// steps its internal state (ramp counter, LFSR, impulse-first flag) on advance.
module fir_stim_pattern_gen
    import fir_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       advance,
    input  logic       restart,
    output logic [7:0] sample
);

    logic [7:0] ramp_q;
    logic [7:0] lfsr_q;
    logic       first_q;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            ramp_q  <= 8'h00;
            lfsr_q  <= LFSR_SEED;
            first_q <= 1'b1;
        end else if (advance) begin
            ramp_q  <= ramp_q + 8'h01;
            lfsr_q  <= lfsr_next(lfsr_q);
            first_q <= 1'b0;
        end
    end

    always_comb begin
        sample = 8'h00;
        unique case (mode_e'(mode))
            MODE_IMPULSE: sample = first_q ? IMPULSE_AMP : 8'h00;
            MODE_STEP:    sample = STEP_AMP;
            MODE_RAMP:    sample = ramp_q;
            MODE_LFSR:    sample = lfsr_q;
            default:      sample = 8'h00;
        endcase
    end

endmodule

// File: rtl/fir_stim_tx.sv
// Self-test transmit driver for the FIR input port: loads the coefficient set,
// then streams a selectable waveform with a strobe every RATE_DIV cycles.
module fir_stim_tx
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = 4,
    parameter int DATA_W   = 8,
    parameter int RATE_DIV = 4,
    parameter logic [NUM_TAPS*DATA_W-1:0] COEFFS = {8'h10, 8'h20, 8'h20, 8'h10}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [7:0]        num_samples,
    output logic [DATA_W-1:0] x_n,
    output logic              s_axis_fir_tvalid,
    output logic              s_set_coeffs,
    output logic              busy,
    output logic              done
);

    localparam int TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int RATE_W = $clog2(RATE_DIV) + 1;
    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(NUM_TAPS - 1);
    localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RATE_DIV - 1);

    state_e            state;
    logic [TAP_W-1:0]  tap_cnt;
    logic [RATE_W-1:0] rate_cnt;
    logic [7:0]        samp_cnt;
    logic [1:0]        mode_q;
    logic [7:0]        nsamp_q;

    logic       run_start;
    logic       stream_last;
    logic       emit;
    logic [7:0] pat_sample;

    function automatic logic [DATA_W-1:0] coef_at(input int k);
        return COEFFS[k*DATA_W +: DATA_W];
    endfunction

    // stream_last marks the cycle carrying the final pulse of a finite run
    always_comb begin
        run_start   = (state == IDLE) && start && !stop;
        stream_last = (state == STREAM) && s_axis_fir_tvalid &&
                      (nsamp_q != 8'd0) && (samp_cnt == nsamp_q);
        emit        = !stop && ((state == GAP) ||
                      ((state == STREAM) && !stream_last && (rate_cnt == RATE_LAST)));
    end

    fir_stim_pattern_gen u_pattern (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode_q),
        .advance (emit),
        .restart (run_start),
        .sample  (pat_sample)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            tap_cnt           <= '0;
            rate_cnt          <= '0;
            samp_cnt          <= 8'd0;
            mode_q            <= 2'd0;
            nsamp_q           <= 8'd0;
            x_n               <= '0;
            s_axis_fir_tvalid <= 1'b0;
            s_set_coeffs      <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else if (state != IDLE && stop) begin
            state             <= IDLE;
            x_n               <= '0;
            s_axis_fir_tvalid <= 1'b0;
            s_set_coeffs      <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    x_n               <= '0;
                    s_axis_fir_tvalid <= 1'b0;
                    s_set_coeffs      <= 1'b0;
                    busy              <= 1'b0;
                    done              <= 1'b0;
                    if (run_start) begin
                        state             <= LOAD;
                        mode_q            <= mode;
                        nsamp_q           <= num_samples;
                        tap_cnt           <= '0;
                        rate_cnt          <= '0;
                        samp_cnt          <= 8'd0;
                        x_n               <= coef_at(0);
                        s_axis_fir_tvalid <= 1'b1;
                        s_set_coeffs      <= 1'b1;
                        busy              <= 1'b1;
                    end
                end
                LOAD: begin
                    if (tap_cnt == TAP_LAST) begin
                        state             <= GAP;
                        x_n               <= '0;
                        s_axis_fir_tvalid <= 1'b0;
                        s_set_coeffs      <= 1'b0;
                    end else begin
                        tap_cnt <= tap_cnt + 1'b1;
                        x_n     <= coef_at(int'(tap_cnt) + 1);
                    end
                end
                GAP: begin
                    state             <= STREAM;
                    rate_cnt          <= '0;
                    samp_cnt          <= 8'd1;
                    s_axis_fir_tvalid <= 1'b1;
                    x_n               <= DATA_W'(pat_sample);
                end
                STREAM: begin
                    if (stream_last) begin
                        state             <= DONE;
                        s_axis_fir_tvalid <= 1'b0;
                        done              <= 1'b1;
                    end else if (rate_cnt == RATE_LAST) begin
                        rate_cnt          <= '0;
                        samp_cnt          <= samp_cnt + 8'd1;
                        s_axis_fir_tvalid <= 1'b1;
                        x_n               <= DATA_W'(pat_sample);
                    end else begin
                        rate_cnt          <= rate_cnt + 1'b1;
                        s_axis_fir_tvalid <= 1'b0;
                    end
                end
                DONE: begin
                    state             <= IDLE;
                    x_n               <= '0;
                    s_axis_fir_tvalid <= 1'b0;
                    busy              <= 1'b0;
                    done              <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stim_tx.sv
// Directed bench for fir_stim_tx: two instances (strobe every 4 cycles and
// continuous strobe) with a per-instance queue of expected strobed bytes.
module tb_fir_stim_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a;
    logic       start_b;
    logic       stop;
    logic [1:0] mode;
    logic [7:0] num_samples;

    logic [7:0] x_a, x_b;
    logic       tv_a, tv_b, set_a, set_b, busy_a, busy_b, done_a, done_b;

    int checks = 0;
    int errors = 0;

    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [8:0] ea, eb;

    logic [7:0] coef_tab [4] = '{8'h10, 8'h20, 8'h20, 8'h10};

    always #5 clk = ~clk;

    fir_stim_tx #(.NUM_TAPS(4), .DATA_W(8), .RATE_DIV(4), .COEFFS(32'h10202010)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .stop(stop), .mode(mode),
        .num_samples(num_samples), .x_n(x_a), .s_axis_fir_tvalid(tv_a),
        .s_set_coeffs(set_a), .busy(busy_a), .done(done_a)
    );

    fir_stim_tx #(.NUM_TAPS(4), .DATA_W(8), .RATE_DIV(1), .COEFFS(32'h10202010)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .stop(stop), .mode(mode),
        .num_samples(num_samples), .x_n(x_b), .s_axis_fir_tvalid(tv_b),
        .s_set_coeffs(set_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input bit sel, input string tag,
                           input logic tv, input logic sc, input logic bz, input logic dn);
        string p;
        p = sel ? "b_" : "a_";
        chk({p, tag, "_tvalid"}, sel ? tv_b : tv_a, tv);
        chk({p, tag, "_set"},    sel ? set_b : set_a, sc);
        chk({p, tag, "_busy"},   sel ? busy_b : busy_a, bz);
        chk({p, tag, "_done"},   sel ? done_b : done_a, dn);
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic push_exp(input bit sel, input logic [8:0] v);
        if (sel) qb.push_back(v);
        else     qa.push_back(v);
    endtask

    // Strobed-byte scoreboards: every tvalid cycle must match the next queued entry
    always @(negedge clk) begin
        if (reset === 1'b0 && tv_a === 1'b1) begin
            if (qa.size() == 0) chk("a_extra_tvalid", tv_a, 0);
            else begin
                ea = qa.pop_front();
                chk("a_sb_set", set_a, ea[8]);
                chk("a_sb_x", x_a, ea[7:0]);
            end
        end
        if (reset === 1'b0 && tv_b === 1'b1) begin
            if (qb.size() == 0) chk("b_extra_tvalid", tv_b, 0);
            else begin
                eb = qb.pop_front();
                chk("b_sb_set", set_b, eb[8]);
                chk("b_sb_x", x_b, eb[7:0]);
            end
        end
    end

    // One complete finite run, checked cycle by cycle from start to IDLE
    task automatic run(input bit sel, input logic [1:0] m, input int n, input bit mid_start);
        int rate;
        int ncyc;
        logic [7:0] s;
        logic [7:0] v;
        logic [7:0] samp[$];
        rate = sel ? 1 : 4;
        s = 8'h01;
        for (int k = 0; k < 4; k++) push_exp(sel, {1'b1, coef_tab[k]});
        for (int i = 0; i < n; i++) begin
            case (m)
                2'd0:    v = (i == 0) ? 8'h7F : 8'h00;
                2'd1:    v = 8'h40;
                2'd2:    v = 8'(i);
                default: begin v = s; s = lfsr_step(s); end
            endcase
            samp.push_back(v);
            push_exp(sel, {1'b0, v});
        end
        mode = m;
        num_samples = 8'(n);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_ctl(sel, "load", 1'b1, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
        end
        chk_ctl(sel, "gap", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("gap_x", sel ? x_b : x_a, 0);
        @(negedge clk);
        ncyc = (n - 1) * rate + 1;
        for (int c = 0; c < ncyc; c++) begin
            chk_ctl(sel, "stream", (c % rate) == 0, 1'b0, 1'b1, 1'b0);
            chk("stream_hold_x", sel ? x_b : x_a, samp[c / rate]);
            if (mid_start && c == 1) begin
                mode = m + 2'd1;
                num_samples = 8'(n + 5);
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
        end
        chk_ctl(sel, "done", 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk_ctl(sel, "idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_x", sel ? x_b : x_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;
        reset = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        stop = 1'b0;
        mode = 2'd0;
        num_samples = 8'd0;

        // reset held three cycles with start high
        repeat (3) @(negedge clk);
        chk_ctl(0, "reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_x", x_a, 0);
        chk_ctl(1, "reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        chk_ctl(0, "post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // step waveform, three samples, strobe every 4 cycles
        run(0, 2'd1, 3, 0);

        // impulse on the continuous-strobe instance
        run(1, 2'd0, 3, 0);

        // ramp, continuous, 258 samples then stop
        for (int k = 0; k < 4; k++) qa.push_back({1'b1, coef_tab[k]});
        for (int j = 0; j < 258; j++) qa.push_back({1'b0, 8'(j)});
        mode = 2'd2;
        num_samples = 8'd0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        saw_done = 1'b0;
        for (int c = 0; c <= 1028; c++) begin
            saw_done = saw_done | done_a;
            if (c == 1020) chk("ramp_ff", x_a, 8'hFF);
            if (c == 1024) chk("ramp_wrap_00", x_a, 8'h00);
            if (c < 1028) @(negedge clk);
        end
        chk("ramp_last_x", x_a, 8'h01);
        chk("ramp_last_tvalid", tv_a, 1'b1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_ctl(0, "ramp_stop", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ramp_stop_x", x_a, 0);
        chk("ramp_no_done", saw_done, 1'b0);

        // LFSR: second start must reseed and repeat; longer run exercises feedback
        run(0, 2'd3, 4, 0);
        run(0, 2'd3, 4, 0);
        run(1, 2'd3, 12, 0);

        // stop during the second LOAD cycle
        qa.push_back({1'b1, coef_tab[0]});
        qa.push_back({1'b1, coef_tab[1]});
        mode = 2'd1;
        num_samples = 8'd3;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        chk("load2_set", set_a, 1'b1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_ctl(0, "load_stop", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_ctl(0, "load_stop_hold", 1'b0, 1'b0, 1'b0, 1'b0);

        // start together with stop in IDLE is ignored
        start_a = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        stop = 1'b0;
        chk_ctl(0, "start_stop", 1'b0, 1'b0, 1'b0, 1'b0);

        // start pulsed mid-stream changes neither count nor mode
        run(0, 2'd1, 3, 1);
        run(1, 2'd0, 4, 1);

        chk("qa_empty", qa.size(), 0);
        chk("qb_empty", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
